// File: rtl/posit_mul_seq.sv
// Sequencer feeding a bit-serial posit-weight multiplier: latches an activation, streams
// the weight MSB first, collects the product. Optional WAIT timeout: POSIT_SEQ_TIMEOUT_EN.
module posit_mul_seq #(
  parameter int unsigned ACT_WIDTH = 16,
  parameter int unsigned EXP_WIDTH = 5,
  parameter int unsigned MAN_WIDTH = 10,
  parameter int unsigned W_MAX     = 8,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  input  logic [3:0]             cfg_precision,
  output logic                   cfg_ready,
  input  logic                   req_valid,
  input  logic [ACT_WIDTH-1:0]   req_act,
  input  logic [W_MAX-1:0]       req_w,
  output logic                   req_ready,
  output logic [ACT_WIDTH-1:0]   mul_act,
  output logic                   mul_w,
  output logic                   mul_valid,
  output logic                   mul_set,
  output logic [3:0]             mul_precision,
  input  logic                   mul_sign,
  input  logic [EXP_WIDTH-1:0]   mul_exp,
  input  logic [MAN_WIDTH+3:0]   mul_man,
  input  logic                   mul_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_sign,
  output logic [EXP_WIDTH-1:0]   res_exp,
  output logic [MAN_WIDTH+3:0]   res_man,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned RES_MAN_W = MAN_WIDTH + 4;
  localparam int unsigned CNT_W     = $clog2(W_MAX + 1);

  typedef enum logic [2:0] {IDLE, SET, STREAM, WAIT, OUT} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             prec_q, prec_d;
  logic                   needs_set_q, needs_set_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [W_MAX-1:0]       shreg_q, shreg_d;
  logic [ACT_WIDTH-1:0]   act_d;
  logic                   w_d, valid_d, set_d;
  logic                   res_valid_d, res_sign_d;
  logic [EXP_WIDTH-1:0]   res_exp_d;
  logic [RES_MAN_W-1:0]   res_man_d;
  logic [3:0]             cfg_clamped_c;

`ifdef POSIT_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          err_d;
`else
  assign err = 1'b0;
`endif

  // cfg wins over a simultaneous request
  assign req_ready     = cfg_ready & ~cfg_valid;
  assign mul_precision = prec_q;

  // Clamp requested precision into [2, W_MAX]
  always_comb begin
    cfg_clamped_c = cfg_precision;
    if (cfg_precision < 4'd2)
      cfg_clamped_c = 4'd2;
    else if (32'(cfg_precision) > W_MAX)
      cfg_clamped_c = 4'(W_MAX);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    prec_d      = prec_q;
    needs_set_d = needs_set_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    act_d       = mul_act;
    w_d         = 1'b0;
    valid_d     = 1'b0;
    set_d       = 1'b0;
    res_valid_d = res_valid;
    res_sign_d  = res_sign;
    res_exp_d   = res_exp;
    res_man_d   = res_man;
`ifdef POSIT_SEQ_TIMEOUT_EN
    timer_d     = timer_q;
    err_d       = err;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          prec_d      = cfg_clamped_c;
          needs_set_d = 1'b1;
        end else if (req_valid) begin
          act_d = req_act;
          cnt_d = CNT_W'(prec_q - 4'd1);
          if (needs_set_q) begin
            state_d = SET;
            set_d   = 1'b1;
            shreg_d = req_w;
          end else begin
            state_d = STREAM;
            valid_d = 1'b1;
            w_d     = req_w[W_MAX-1];
            shreg_d = {req_w[W_MAX-2:0], 1'b0};
          end
        end
      end
      SET: begin
        needs_set_d = 1'b0;
        state_d     = STREAM;
        valid_d     = 1'b1;
        w_d         = shreg_q[W_MAX-1];
        shreg_d     = {shreg_q[W_MAX-2:0], 1'b0};
      end
      STREAM: begin
        // cnt_q counts bits still to send after the one on the wire
        if (cnt_q == CNT_W'(0)) begin
          if (mul_done) begin
            state_d     = OUT;
            res_valid_d = 1'b1;
            res_sign_d  = mul_sign;
            res_exp_d   = mul_exp;
            res_man_d   = mul_man;
          end else begin
            state_d = WAIT;
`ifdef POSIT_SEQ_TIMEOUT_EN
            timer_d = '0;
`endif
          end
        end else begin
          valid_d = 1'b1;
          w_d     = shreg_q[W_MAX-1];
          shreg_d = {shreg_q[W_MAX-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      WAIT: begin
        if (mul_done) begin
          state_d     = OUT;
          res_valid_d = 1'b1;
          res_sign_d  = mul_sign;
          res_exp_d   = mul_exp;
          res_man_d   = mul_man;
        end
`ifdef POSIT_SEQ_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prec_q      <= 4'd4;
      needs_set_q <= 1'b1;
      cnt_q       <= '0;
      shreg_q     <= '0;
      mul_act     <= '0;
      mul_w       <= 1'b0;
      mul_valid   <= 1'b0;
      mul_set     <= 1'b0;
      res_valid   <= 1'b0;
      res_sign    <= 1'b0;
      res_exp     <= '0;
      res_man     <= '0;
      busy        <= 1'b0;
      cfg_ready   <= 1'b1;
`ifdef POSIT_SEQ_TIMEOUT_EN
      timer_q     <= '0;
      err         <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prec_q      <= prec_d;
      needs_set_q <= needs_set_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      mul_act     <= act_d;
      mul_w       <= w_d;
      mul_valid   <= valid_d;
      mul_set     <= set_d;
      res_valid   <= res_valid_d;
      res_sign    <= res_sign_d;
      res_exp     <= res_exp_d;
      res_man     <= res_man_d;
      busy        <= (state_d != IDLE);
      cfg_ready   <= (state_d == IDLE);
`ifdef POSIT_SEQ_TIMEOUT_EN
      timer_q     <= timer_d;
      err         <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_posit_mul_seq.sv
// Directed bench for posit_mul_seq: set/stream sequencing, result hold, cfg priority,
// precision clamping, mid-stream reset, and WAIT behaviour with or without the timeout.
module tb_posit_mul_seq;
  localparam int unsigned TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst, cfg_valid, cfg_ready, req_valid, req_ready;
  logic [3:0]  cfg_precision, mul_precision;
  logic [15:0] req_act, mul_act;
  logic [7:0]  req_w;
  logic        mul_w, mul_valid, mul_set, mul_sign, mul_done;
  logic [4:0]  mul_exp, res_exp;
  logic [13:0] mul_man, res_man;
  logic        res_valid, res_ready, res_sign, busy, err;

  int checks = 0;
  int errors = 0;

  posit_mul_seq #(.ACT_WIDTH(16), .EXP_WIDTH(5), .MAN_WIDTH(10), .W_MAX(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_precision(cfg_precision), .cfg_ready(cfg_ready),
    .req_valid(req_valid), .req_act(req_act), .req_w(req_w), .req_ready(req_ready),
    .mul_act(mul_act), .mul_w(mul_w), .mul_valid(mul_valid), .mul_set(mul_set),
    .mul_precision(mul_precision),
    .mul_sign(mul_sign), .mul_exp(mul_exp), .mul_man(mul_man), .mul_done(mul_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_sign(res_sign),
    .res_exp(res_exp), .res_man(res_man), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_precision = 4'd0; req_valid = 1'b0; req_act = '0; req_w = '0;
    mul_sign = 1'b0; mul_exp = '0; mul_man = '0; mul_done = 1'b0; res_ready = 1'b0;
    @(negedge clk); step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %b%b exp 00", busy, err); end
    checks++; if (mul_precision !== 4'd4) begin errors++; $display("FAIL reset_prec got %0d exp 4", mul_precision); end
    checks++; if ({mul_valid, mul_set, mul_w, mul_act} !== 19'd0) begin errors++; $display("FAIL reset_mul got %b%b%b %h exp 0", mul_valid, mul_set, mul_w, mul_act); end
    checks++; if ({res_valid, res_sign, res_exp, res_man} !== 21'd0) begin errors++; $display("FAIL reset_res got %b %b %h %h exp 0", res_valid, res_sign, res_exp, res_man); end
    rst = 1'b0;
  endtask

  task automatic test_first_op();
    logic [3:0] bits;
    bits = 4'b1011;
    req_valid = 1'b1; req_act = 16'h1234; req_w = 8'b1011_0000;
    step(); req_valid = 1'b0; req_act = 16'hdead;
    checks++; if (mul_set !== 1'b1 || mul_valid !== 1'b0) begin errors++; $display("FAIL first_set got set=%b valid=%b exp 1 0", mul_set, mul_valid); end
    checks++; if (mul_act !== 16'h1234 || busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL first_act got %h busy=%b rdy=%b exp 1234 1 0", mul_act, busy, req_ready); end
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mul_valid !== 1'b1 || mul_set !== 1'b0 || mul_w !== bits[3-i]) begin errors++; $display("FAIL first_bit%0d got v=%b s=%b w=%b exp 1 0 %b", i, mul_valid, mul_set, mul_w, bits[3-i]); end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (mul_valid !== 1'b0 || mul_w !== 1'b0 || mul_act !== 16'h1234) begin errors++; $display("FAIL first_wait%0d got v=%b w=%b act=%h exp 0 0 1234", i, mul_valid, mul_w, mul_act); end
      step();
    end
    mul_done = 1'b1; mul_sign = 1'b0; mul_exp = 5'b00010; mul_man = 14'b01001010011100;
    step();
    mul_done = 1'b0; mul_sign = 1'b1; mul_exp = 5'h1f; mul_man = 14'h3fff;
    req_valid = 1'b1; req_act = 16'hbeef; req_w = 8'hff;
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid !== 1'b1 || res_sign !== 1'b0 || res_exp !== 5'b00010 || res_man !== 14'b01001010011100) begin errors++; $display("FAIL first_hold%0d got %b %b %b %b", i, res_valid, res_sign, res_exp, res_man); end
      checks++; if (req_ready !== 1'b0 || mul_valid !== 1'b0 || mul_set !== 1'b0) begin errors++; $display("FAIL first_inflight%0d got rdy=%b v=%b s=%b exp 000", i, req_ready, mul_valid, mul_set); end
      step();
    end
    req_valid = 1'b0; res_ready = 1'b1;
    step(); res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL first_release got v=%b busy=%b cfg_rdy=%b exp 0 0 1", res_valid, busy, cfg_ready); end
  endtask

  task automatic test_no_set();
    logic [3:0] bits;
    bits = 4'b0110;
    req_valid = 1'b1; req_act = 16'hf234; req_w = 8'b0110_0000;
    step(); req_valid = 1'b0;
    mul_done = 1'b1; mul_sign = 1'b1; mul_exp = 5'h07; mul_man = 14'h0123;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mul_valid !== 1'b1 || mul_set !== 1'b0 || mul_w !== bits[3-i] || mul_act !== 16'hf234) begin errors++; $display("FAIL noset_bit%0d got v=%b s=%b w=%b act=%h exp 1 0 %b f234", i, mul_valid, mul_set, mul_w, mul_act, bits[3-i]); end
      mul_done = (i >= 2);
      if (i == 3) begin mul_sign = 1'b1; mul_exp = 5'h1f; mul_man = 14'h3fff; end
      step();
    end
    mul_done = 1'b0; mul_exp = 5'h00; mul_man = 14'h0000;
    checks++; if (res_valid !== 1'b1 || mul_valid !== 1'b0 || {res_sign, res_exp, res_man} !== {1'b1, 5'h1f, 14'h3fff}) begin errors++; $display("FAIL noset_done_last got v=%b mv=%b %b %h %h exp 1 0 1 1f 3fff", res_valid, mul_valid, res_sign, res_exp, res_man); end
    res_ready = 1'b1; step(); res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL noset_release got v=%b busy=%b exp 0 0", res_valid, busy); end
  endtask

  task automatic test_cfg_priority();
    logic [7:0] bits;
    bits = 8'b1100_1010;
    cfg_valid = 1'b1; cfg_precision = 4'd15; req_valid = 1'b1; req_act = 16'h0abc; req_w = bits;
    #1;
    checks++; if (req_ready !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL prio_ready got req=%b cfg=%b exp 0 1", req_ready, cfg_ready); end
    step(); cfg_valid = 1'b0;
    checks++; if (mul_precision !== 4'd8 || busy !== 1'b0 || mul_set !== 1'b0 || mul_valid !== 1'b0) begin errors++; $display("FAIL prio_cfg got prec=%0d busy=%b s=%b v=%b exp 8 0 0 0", mul_precision, busy, mul_set, mul_valid); end
    step(); req_valid = 1'b0;
    checks++; if (mul_set !== 1'b1 || mul_act !== 16'h0abc) begin errors++; $display("FAIL prio_set got s=%b act=%h exp 1 0abc", mul_set, mul_act); end
    step();
    for (int i = 0; i < 8; i++) begin
      checks++; if (mul_valid !== 1'b1 || mul_w !== bits[7-i]) begin errors++; $display("FAIL prio_bit%0d got v=%b w=%b exp 1 %b", i, mul_valid, mul_w, bits[7-i]); end
      step();
    end
    checks++; if (mul_valid !== 1'b0) begin errors++; $display("FAIL prio_wait got v=%b exp 0", mul_valid); end
    mul_done = 1'b1; mul_sign = 1'b0; mul_exp = 5'h15; mul_man = 14'h2aaa;
    step(); mul_done = 1'b0;
    checks++; if (res_valid !== 1'b1 || {res_sign, res_exp, res_man} !== {1'b0, 5'h15, 14'h2aaa}) begin errors++; $display("FAIL prio_res got %b %b %h %h", res_valid, res_sign, res_exp, res_man); end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_clamp_low();
    cfg_valid = 1'b1; cfg_precision = 4'd1;
    step(); cfg_valid = 1'b0;
    checks++; if (mul_precision !== 4'd2) begin errors++; $display("FAIL clamp_prec got %0d exp 2", mul_precision); end
    req_valid = 1'b1; req_act = 16'h5555; req_w = 8'b0111_1111;
    step(); req_valid = 1'b0;
    checks++; if (mul_set !== 1'b1) begin errors++; $display("FAIL clamp_set got %b exp 1", mul_set); end
    step();
    checks++; if (mul_valid !== 1'b1 || mul_w !== 1'b0) begin errors++; $display("FAIL clamp_bit0 got v=%b w=%b exp 1 0", mul_valid, mul_w); end
    step();
    checks++; if (mul_valid !== 1'b1 || mul_w !== 1'b1) begin errors++; $display("FAIL clamp_bit1 got v=%b w=%b exp 1 1", mul_valid, mul_w); end
    step();
    checks++; if (mul_valid !== 1'b0 || mul_w !== 1'b0) begin errors++; $display("FAIL clamp_stop got v=%b w=%b exp 0 0", mul_valid, mul_w); end
    mul_done = 1'b1; mul_exp = 5'h01; mul_man = 14'h0001;
    step(); mul_done = 1'b0;
    res_ready = 1'b1; step(); res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clamp_release got v=%b busy=%b exp 0 0", res_valid, busy); end
  endtask

  task automatic test_reset_mid_stream();
    logic [3:0] bits;
    bits = 4'b1001;
    cfg_valid = 1'b1; cfg_precision = 4'd6;
    step(); cfg_valid = 1'b0;
    req_valid = 1'b1; req_act = 16'h7777; req_w = 8'b1010_1010;
    step(); req_valid = 1'b0;
    step();
    step();
    checks++; if (mul_valid !== 1'b1 || mul_w !== 1'b0) begin errors++; $display("FAIL rst_bit1 got v=%b w=%b exp 1 0", mul_valid, mul_w); end
    rst = 1'b1; mul_done = 1'b1;
    step(); rst = 1'b0; mul_done = 1'b0;
    checks++; if (busy !== 1'b0 || mul_valid !== 1'b0 || mul_precision !== 4'd4 || cfg_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got busy=%b v=%b prec=%0d cfg=%b res=%b exp 0 0 4 1 0", busy, mul_valid, mul_precision, cfg_ready, res_valid); end
    req_valid = 1'b1; req_act = 16'h0f0f; req_w = 8'b1001_0000;
    step(); req_valid = 1'b0;
    checks++; if (mul_set !== 1'b1) begin errors++; $display("FAIL rst_reset_set got %b exp 1", mul_set); end
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mul_valid !== 1'b1 || mul_w !== bits[3-i]) begin errors++; $display("FAIL rst_bit%0d got v=%b w=%b exp 1 %b", i, mul_valid, mul_w, bits[3-i]); end
      step();
    end
  endtask

`ifdef POSIT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    for (int k = 1; k < int'(TIMEOUT); k++) begin
      step();
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early%0d got err=%b busy=%b exp 0 1", k, err, busy); end
    end
    step();
    checks++; if (err !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL tmo_fire got err=%b busy=%b res=%b exp 1 0 0", err, busy, res_valid); end
    mul_done = 1'b1;
    step(); mul_done = 1'b0;
    step();
    checks++; if (err !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL tmo_sticky got err=%b res=%b busy=%b exp 1 0 0", err, res_valid, busy); end
  endtask
`else
  task automatic test_no_timeout();
    repeat (int'(TIMEOUT) + 8) step();
    checks++; if (err !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0 || mul_valid !== 1'b0) begin errors++; $display("FAIL wait_long got err=%b busy=%b res=%b v=%b exp 0 1 0 0", err, busy, res_valid, mul_valid); end
    mul_done = 1'b1; mul_sign = 1'b1; mul_exp = 5'h0a; mul_man = 14'h1555;
    step(); mul_done = 1'b0;
    checks++; if (res_valid !== 1'b1 || {res_sign, res_exp, res_man} !== {1'b1, 5'h0a, 14'h1555}) begin errors++; $display("FAIL wait_long_res got %b %b %h %h", res_valid, res_sign, res_exp, res_man); end
    res_ready = 1'b1; step(); res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wait_long_release got v=%b busy=%b exp 0 0", res_valid, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_op();
    test_no_set();
    test_cfg_priority();
    test_clamp_low();
    test_reset_mid_stream();
`ifdef POSIT_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
